// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array operand feed controller.
package systolic_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int LANES     = 4;
  localparam int ADDR_BITS = 4;

  // LSB of lane 'lane' inside the flattened per-lane address bus.
  function automatic int lane_lsb(input int lane, input int aw);
    return lane * aw;
  endfunction

endpackage

// File: rtl/systolic_lane_gen.sv
// One lane of the feed: skewed read window, host write select, and the
// one-cycle delayed operand-valid that lines up with the RAM read latency.
module systolic_lane_gen
  import systolic_pkg::*;
#(
  parameter int LANE      = 0,
  parameter int K         = 4,
  parameter int ADDR_W    = ADDR_BITS,
  parameter int BASE_ADDR = 0,
  parameter int TW        = 3
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [TW-1:0]     i_t,
  input  logic              i_active,
  input  logic              i_host_sel,
  input  logic [ADDR_W-1:0] i_host_addr,
  output logic              o_en,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid
);

  localparam logic [TW:0] LO = (TW+1)'(LANE);
  localparam logic [TW:0] KW = (TW+1)'(K);

  logic [TW:0]       w_rel;
  logic              w_feed;
  logic [ADDR_W-1:0] w_addr;
  logic              r_feed;

  // t < LANE wraps to a value >= 2^TW, which is always above K.
  assign w_rel  = {1'b0, i_t} - LO;
  assign w_feed = i_active && (w_rel < KW);
  assign w_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(w_rel);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_feed  <= 1'b0;
      o_en    <= 1'b0;
      o_we    <= 1'b0;
      o_addr  <= '0;
      o_valid <= 1'b0;
    end else begin
      r_feed  <= w_feed;
      o_valid <= r_feed;
      o_en    <= w_feed | i_host_sel;
      o_we    <= i_host_sel;
      o_addr  <= i_host_sel ? i_host_addr : (w_feed ? w_addr : '0);
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequences the per-lane operand RAMs feeding the systolic array: skewed
// streaming on start, a fixed drain, a done pulse, and host loading while idle.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int N         = LANES,
  parameter int ADDR_W    = ADDR_BITS,
  parameter int K         = 4,
  parameter int BASE_ADDR = 0,
  parameter int DRAIN     = 8,
  localparam int LW       = (N > 1) ? $clog2(N) : 1,
  localparam int TW       = $clog2(K + N),
  localparam int DW       = (DRAIN > 1) ? $clog2(DRAIN) : 1
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                host_wr,
  input  logic [LW-1:0]       host_lane,
  input  logic [ADDR_W-1:0]   host_addr,
  output logic                host_err,
  output logic [N-1:0]        ram_en,
  output logic [N-1:0]        ram_we,
  output logic [N*ADDR_W-1:0] ram_addr,
  output logic [N-1:0]        lane_valid
);

  localparam logic [TW-1:0] T_LAST = TW'(K + N - 2);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN - 1);

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_t, w_t_nxt;
  logic [DW-1:0] r_d, w_d_nxt;
  logic          r_pre, w_pre_nxt;
  logic          r_busy, r_done, r_err;
  logic          w_lane_ok, w_host_ok, w_feed_nxt;
  logic [N-1:0]  w_host_sel;

  generate
    if ((2 ** LW) > N) begin : g_lane_chk
      assign w_lane_ok = (host_lane < LW'(N));
    end else begin : g_lane_all
      assign w_lane_ok = 1'b1;
    end
  endgenerate

  assign w_host_ok = (r_state == S_IDLE) && host_wr && w_lane_ok;

  // r_pre marks the write-only cycle that precedes t=0 when start and a
  // host write coincide, so feed and write never share the RAM port.
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_d_nxt     = r_d;
    w_pre_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FEED;
          w_t_nxt     = '0;
          w_pre_nxt   = w_host_ok;
        end
      end
      S_FEED: begin
        if (r_pre) begin
          w_t_nxt = '0;
        end else if (r_t == T_LAST) begin
          w_state_nxt = S_DRAIN;
          w_d_nxt     = '0;
        end else begin
          w_t_nxt = r_t + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_d == D_LAST) w_state_nxt = S_DONE;
        else               w_d_nxt     = r_d + 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_feed_nxt = (w_state_nxt == S_FEED) && !w_pre_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_d     <= '0;
      r_pre   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      r_d     <= w_d_nxt;
      r_pre   <= w_pre_nxt;
      r_busy  <= (w_state_nxt == S_FEED) || (w_state_nxt == S_DRAIN);
      r_done  <= (w_state_nxt == S_DONE);
      r_err   <= host_wr && !w_host_ok;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign host_err = r_err;

  // Lanes see next-cycle t so their registered outputs land in the FEED cycle.
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign w_host_sel[g] = w_host_ok && (host_lane == LW'(g));

    systolic_lane_gen #(
      .LANE      (g),
      .K         (K),
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR),
      .TW        (TW)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .i_t         (w_t_nxt),
      .i_active    (w_feed_nxt),
      .i_host_sel  (w_host_sel[g]),
      .i_host_addr (host_addr),
      .o_en        (ram_en[g]),
      .o_we        (ram_we[g]),
      .o_addr      (ram_addr[lane_lsb(g, ADDR_W) +: ADDR_W]),
      .o_valid     (lane_valid[g])
    );
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench: two controller configurations share random and directed
// stimulus; a cycle-indexed pass model predicts every output of every cycle.
module tb_systolic_feed_ctrl;

  localparam int NL = 4;
  localparam int AW = 4;
  localparam int DR = 8;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          err;
    logic [NL-1:0] en;
    logic [NL-1:0] we;
    logic [NL*AW-1:0] addr;
    logic [NL-1:0] lv;
  } obs_t;

  logic clk, rst, start, host_wr;
  logic [1:0]    host_lane;
  logic [AW-1:0] host_addr;

  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [NL-1:0] en_a, we_a, lv_a, en_b, we_b, lv_b;
  logic [NL*AW-1:0] addr_a, addr_b;

  systolic_feed_ctrl #(.N(NL), .ADDR_W(AW), .K(4), .BASE_ADDR(0), .DRAIN(DR)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
    .host_wr(host_wr), .host_lane(host_lane), .host_addr(host_addr), .host_err(err_a),
    .ram_en(en_a), .ram_we(we_a), .ram_addr(addr_a), .lane_valid(lv_a));

  systolic_feed_ctrl #(.N(NL), .ADDR_W(AW), .K(9), .BASE_ADDR(1), .DRAIN(DR)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
    .host_wr(host_wr), .host_lane(host_lane), .host_addr(host_addr), .host_err(err_b),
    .ram_en(en_b), .ram_we(we_b), .ram_addr(addr_b), .lane_valid(lv_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic stop    = 1'b0;
  obs_t q0[$];
  obs_t q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t got=%h expected=%h", nm, $time, act, req);
    end
  endtask

  // Reference: a pass is described by the cycle its t=0 falls on; everything
  // else follows from cycle arithmetic on that anchor.
  int   KP[2] = '{4, 9};
  int   BP[2] = '{0, 1};
  int   m_in[2]    = '{0, 0};
  int   m_feed0[2] = '{0, 0};
  int   m_done[2]  = '{0, 0};
  int   ecnt, c, t;
  logic m_idle, m_wr;
  obs_t m_x;

  initial begin
    ecnt = 0;
    forever begin
      @(posedge clk);
      if (!stop) begin
        for (int u = 0; u < 2; u++) begin
          m_x = '0;
          if (rst) begin
            m_in[u] = 0;
          end else begin
            if (m_in[u] != 0 && ecnt > m_done[u]) m_in[u] = 0;
            m_idle = (m_in[u] == 0);
            m_wr   = m_idle && host_wr;
            m_x.err = host_wr && !m_wr;
            if (m_idle && start) begin
              m_in[u]    = 1;
              m_feed0[u] = ecnt + 1 + (m_wr ? 1 : 0);
              m_done[u]  = m_feed0[u] + KP[u] + NL - 1 + DR;
            end
            if (m_in[u] != 0) begin
              c = ecnt + 1;
              m_x.busy = (c < m_done[u]);
              m_x.done = (c == m_done[u]);
              for (int i = 0; i < NL; i++) begin
                t = c - m_feed0[u] - i;
                if (t >= 0 && t < KP[u]) begin
                  m_x.en[i] = 1'b1;
                  m_x.addr[i*AW +: AW] = AW'(BP[u] + t);
                end
                if (t - 1 >= 0 && t - 1 < KP[u]) m_x.lv[i] = 1'b1;
              end
            end
            if (m_wr) begin
              m_x.en[host_lane] = 1'b1;
              m_x.we[host_lane] = 1'b1;
              m_x.addr[host_lane*AW +: AW] = host_addr;
            end
          end
          if (u == 0) q0.push_back(m_x);
          else        q1.push_back(m_x);
        end
        ecnt++;
      end
    end
  end

  obs_t e0, e1, a0, a1;

  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        a0 = {busy_a, done_a, err_a, en_a, we_a, addr_a, lv_a};
        chk("a ctl", 32'({a0.busy, a0.done, a0.err}), 32'({e0.busy, e0.done, e0.err}));
        chk("a ram", 32'({a0.en, a0.we, a0.addr}), 32'({e0.en, e0.we, e0.addr}));
        chk("a valid", 32'(a0.lv), 32'(e0.lv));
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        a1 = {busy_b, done_b, err_b, en_b, we_b, addr_b, lv_b};
        chk("b ctl", 32'({a1.busy, a1.done, a1.err}), 32'({e1.busy, e1.done, e1.err}));
        chk("b ram", 32'({a1.en, a1.we, a1.addr}), 32'({e1.en, e1.we, e1.addr}));
        chk("b valid", 32'(a1.lv), 32'(e1.lv));
      end
    end
  end

  task automatic drive(input logic s, input logic w, input logic [1:0] l,
                       input logic [AW-1:0] a, input logic r);
    @(negedge clk);
    start = s; host_wr = w; host_lane = l; host_addr = a; rst = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; host_wr = 1'b0; host_lane = '0; host_addr = '0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 2'd0, '0, 1'b1);
    idle(2);

    // Pass with restarts at cycles 2/10/17 and a host write in FEED cycle 3.
    drive(1'b1, 1'b0, 2'd0, '0, 1'b0);
    for (int j = 1; j <= 17; j++)
      drive(j == 2 || j == 10 || j == 17, j == 3, 2'd1, 4'd5, 1'b0);
    idle(25);

    drive(1'b0, 1'b1, 2'd2, 4'd9, 1'b0);
    idle(2);

    // Reset in cycle 5, then a clean pass.
    drive(1'b1, 1'b0, 2'd0, '0, 1'b0);
    for (int j = 1; j <= 5; j++) drive(1'b0, 1'b0, 2'd0, '0, j == 5);
    idle(2);
    drive(1'b1, 1'b0, 2'd0, '0, 1'b0);
    idle(25);

    // start and host write together.
    drive(1'b1, 1'b1, 2'd3, 4'hc, 1'b0);
    idle(25);

    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            2'($urandom), AW'($urandom), $urandom_range(0, 99) == 0);
    idle(30);

    @(posedge clk);
    #1 stop = 1'b1;
    @(negedge clk);
    #1;
    chk("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
